// File: rtl/drowsy_pkg.sv
// Shared types and constants for the drowsiness decision stage:
// class codes, controller states and per-class drowsy weights.
package drowsy_pkg;

  typedef enum logic [1:0] {
    CLS_AWAKE   = 2'd0,
    CLS_YAWN    = 2'd1,
    CLS_CLOSED  = 2'd2,
    CLS_UNKNOWN = 2'd3
  } cls_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP1 = 2'd1,
    ST_CMP2 = 2'd2,
    ST_UPD  = 2'd3
  } state_e;

  localparam int W_YAWN   = 1;
  localparam int W_CLOSED = 2;

  function automatic int sat_inc(input int cur, input int inc, input int lim);
    return (cur + inc > lim) ? lim : cur + inc;
  endfunction

endpackage

// File: rtl/decision_argmax.sv
// Serial argmax over latched class scores: start captures the vector and
// seeds the best entry with index 0; each step compares one more index.
module decision_argmax
  import drowsy_pkg::*;
#(
  parameter int DW   = 10,
  parameter int NCLS = 3
) (
  input  logic          Clock,
  input  logic          Rst,
  input  logic          start_i,
  input  logic          step_i,
  input  logic [1:0]    step_idx_i,
  input  logic [DW-1:0] score_i [NCLS],
  output logic [1:0]    best_idx_o,
  output logic [DW-1:0] best_val_o
);

  logic [DW-1:0] s_q [NCLS];
  logic [1:0]    best_idx_q;
  logic [DW-1:0] best_val_q;
  logic [DW-1:0] cand;

  for (genvar gi = 0; gi < NCLS; gi++) begin : g_lat
    always_ff @(posedge Clock) begin
      if (Rst)          s_q[gi] <= '0;
      else if (start_i) s_q[gi] <= score_i[gi];
    end
  end

  assign cand = s_q[step_idx_i];

  // Strict greater-than keeps the lower index on ties.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      best_idx_q <= '0;
      best_val_q <= '0;
    end else if (start_i) begin
      best_idx_q <= 2'd0;
      best_val_q <= score_i[0];
    end else if (step_i && (cand > best_val_q)) begin
      best_idx_q <= step_idx_i;
      best_val_q <= cand;
    end
  end

  assign best_idx_o = best_idx_q;
  assign best_val_o = best_val_q;

endmodule

// File: rtl/drowsy_decision.sv
// Frame controller: serial argmax of three class scores, then a weighted
// drowsy counter and awake-streak counter that drive a debounced alarm.
module drowsy_decision
  import drowsy_pkg::*;
#(
  parameter int DW           = 10,
  parameter int NCLS         = 3,
  parameter int MIN_SCORE    = 64,
  parameter int ALARM_FRAMES = 4,
  parameter int CLEAR_FRAMES = 3,
  localparam int LW          = $clog2(ALARM_FRAMES + 1),
  localparam int AW          = $clog2(CLEAR_FRAMES + 1)
) (
  input  logic          Clock,
  input  logic          Rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] score [NCLS],
  output logic          out_valid,
  output logic [1:0]    class_out,
  output logic [LW-1:0] drowsy_level,
  output logic          alarm
);

  state_e        state_q;
  logic          in_ready_q, out_valid_q, alarm_q;
  logic [1:0]    class_q;
  logic [LW-1:0] level_q;
  logic [AW-1:0] awake_q;

  logic          start, step;
  logic [1:0]    step_idx, best_idx;
  logic [DW-1:0] best_val;

  cls_e          cls_d;
  logic [LW-1:0] level_d;
  logic [AW-1:0] awake_d;
  logic          alarm_d;

  assign start    = (state_q == ST_IDLE) && in_valid;
  assign step     = (state_q == ST_CMP1) || (state_q == ST_CMP2);
  assign step_idx = (state_q == ST_CMP1) ? 2'd1 : 2'd2;

  decision_argmax #(.DW(DW), .NCLS(NCLS)) u_argmax (
    .Clock      (Clock),
    .Rst        (Rst),
    .start_i    (start),
    .step_i     (step),
    .step_idx_i (step_idx),
    .score_i    (score),
    .best_idx_o (best_idx),
    .best_val_o (best_val)
  );

  always_comb begin
    cls_d   = (best_val < DW'(MIN_SCORE)) ? CLS_UNKNOWN : cls_e'(best_idx);
    level_d = level_q;
    awake_d = awake_q;
    alarm_d = alarm_q;
    case (cls_d)
      CLS_AWAKE: begin
        level_d = '0;
        awake_d = AW'(sat_inc(int'(awake_q), 1, CLEAR_FRAMES));
        if (awake_d == AW'(CLEAR_FRAMES)) alarm_d = 1'b0;
      end
      CLS_YAWN: begin
        level_d = LW'(sat_inc(int'(level_q), W_YAWN, ALARM_FRAMES));
        awake_d = '0;
      end
      CLS_CLOSED: begin
        level_d = LW'(sat_inc(int'(level_q), W_CLOSED, ALARM_FRAMES));
        awake_d = '0;
      end
      default: ;
    endcase
    if (level_d >= LW'(ALARM_FRAMES)) alarm_d = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      class_q     <= '0;
      level_q     <= '0;
      awake_q     <= '0;
      alarm_q     <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q    <= ST_CMP1;
            in_ready_q <= 1'b0;
          end
        end
        ST_CMP1: state_q <= ST_CMP2;
        ST_CMP2: state_q <= ST_UPD;
        ST_UPD: begin
          class_q     <= cls_d;
          level_q     <= level_d;
          awake_q     <= awake_d;
          alarm_q     <= alarm_d;
          out_valid_q <= 1'b1;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign class_out    = class_q;
  assign drowsy_level = level_q;
  assign alarm        = alarm_q;

endmodule

// File: tb/tb_drowsy_decision.sv
// Directed bench for drowsy_decision: a driver queues hand-computed results,
// a monitor pops and compares them on every out_valid pulse.
module tb_drowsy_decision;

  logic       Clock = 1'b0;
  logic       Rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [9:0] score [3];
  logic       in_ready, out_valid, alarm;
  logic [1:0] class_out;
  logic [2:0] drowsy_level;

  typedef struct {
    logic [1:0] cls;
    logic [2:0] lvl;
    logic       alm;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  drowsy_decision dut (
    .Clock        (Clock),
    .Rst          (Rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .score        (score),
    .out_valid    (out_valid),
    .class_out    (class_out),
    .drowsy_level (drowsy_level),
    .alarm        (alarm)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge Clock) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("latency", cyc, mon_e.cyc);
        chk("class_out", {30'd0, class_out}, {30'd0, mon_e.cls});
        chk("drowsy_level", {29'd0, drowsy_level}, {29'd0, mon_e.lvl});
        chk("alarm", {31'd0, alarm}, {31'd0, mon_e.alm});
        $display("txn cyc=%0d class=%0d level=%0d alarm=%0d", cyc, class_out, drowsy_level, alarm);
      end
    end
  end

  // mode 0: normal, 1: extra in_valid during CMP1, 2: reset during CMP2
  task automatic send(input int a, input int b, input int c,
                      input int ecls, input int elvl, input int ealm, input int mode);
    exp_t e;
    int   n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (in_ready !== 1'b1) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    score[0] = a[9:0];
    score[1] = b[9:0];
    score[2] = c[9:0];
    in_valid = 1'b1;
    @(posedge Clock);
    #1 in_valid = 1'b0;
    @(negedge Clock);
    if (mode != 2) begin
      e.cls = ecls[1:0];
      e.lvl = elvl[2:0];
      e.alm = ealm[0];
      e.cyc = cyc + 3;
      q.push_back(e);
    end
    chk("busy_cmp1", {31'd0, in_ready}, 0);
    if (mode == 1) begin
      score[0] = 10'd500;
      score[1] = 10'd10;
      score[2] = 10'd10;
      in_valid = 1'b1;
    end
    @(negedge Clock);
    in_valid = 1'b0;
    chk("busy_cmp2", {31'd0, in_ready}, 0);
    if (mode == 2) begin
      Rst = 1'b1;
      @(negedge Clock);
      chk("rst_in_ready", {31'd0, in_ready}, 1);
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_class", {30'd0, class_out}, 0);
      chk("rst_level", {29'd0, drowsy_level}, 0);
      chk("rst_alarm", {31'd0, alarm}, 0);
      Rst = 1'b0;
      return;
    end
    @(negedge Clock);
    chk("busy_upd", {31'd0, in_ready}, 0);
    @(negedge Clock);
    chk("ready_back", {31'd0, in_ready}, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    score[0] = '0;
    score[1] = '0;
    score[2] = '0;
    repeat (2) @(negedge Clock);
    Rst = 1'b0;
    chk("init_in_ready", {31'd0, in_ready}, 1);
    chk("init_out_valid", {31'd0, out_valid}, 0);
    chk("init_class", {30'd0, class_out}, 0);
    chk("init_level", {29'd0, drowsy_level}, 0);
    chk("init_alarm", {31'd0, alarm}, 0);

    send(100, 300, 200, 1, 1, 0, 0);
    send(250, 250,  10, 0, 0, 0, 0);
    send( 10, 400, 400, 1, 1, 0, 0);
    send( 30,  40,  50, 3, 1, 0, 0);
    send( 63,   0,   0, 3, 1, 0, 0);
    send( 64,   0,   0, 0, 0, 0, 0);
    send( 10,  20, 500, 2, 2, 0, 0);
    send( 10,  20, 500, 2, 4, 1, 0);
    send(500,  10,  10, 0, 0, 1, 0);
    send(500,  10,  10, 0, 0, 1, 0);
    send(500,  10,  10, 0, 0, 0, 0);
    send( 10,  20, 500, 2, 2, 0, 0);
    send( 10,  20, 500, 2, 4, 1, 0);
    send(100, 300, 200, 1, 4, 1, 1);
    send( 10,  20, 500, 0, 0, 0, 2);
    send(100, 300, 200, 1, 1, 0, 0);

    repeat (6) @(negedge Clock);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
